// File: rtl/half_adder.sv
// half_adder: single-bit half adder with a zero-latency sum/carry path,
// a registered copy of the result with a valid strobe, and an optional
// saturating count of enabled cycles that produced a carry.
//
// Build option: define HALF_ADDER_CARRY_CNT_EN to build the carry counter.
// Without it, carry_cnt is constant 0 and clr is ignored.
module half_adder #(
   parameter int unsigned CNT_WIDTH = 16   // counter width, 2..32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 a,
   input  logic                 b,
   input  logic                 en,
   input  logic                 clr,
   output logic                 s,
   output logic                 carry,
   output logic                 s_q,
   output logic                 carry_q,
   output logic                 vld_q,
   output logic [CNT_WIDTH-1:0] carry_cnt
);

   logic s_d;
   logic carry_d;
   logic vld_d;

   // Pure combinational add; reset and clock play no part here
   always_comb begin
      s     = a ^ b;
      carry = a & b;
   end

   // Next state of the result register: capture on en, otherwise hold
   always_comb begin
      s_d     = s_q;
      carry_d = carry_q;
      vld_d   = en;
      if (en) begin
         s_d     = s;
         carry_d = carry;
      end
   end

   // Result register, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q     <= 1'b0;
         carry_q <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         s_q     <= s_d;
         carry_q <= carry_d;
         vld_q   <= vld_d;
      end
   end

`ifdef HALF_ADDER_CARRY_CNT_EN
   logic [CNT_WIDTH-1:0] carry_cnt_d;
   logic [CNT_WIDTH-1:0] carry_cnt_q;

   // Clear beats increment; the count sticks at all-ones instead of wrapping
   always_comb begin
      carry_cnt_d = carry_cnt_q;
      if (clr) begin
         carry_cnt_d = '0;
      end else if (en && carry && (carry_cnt_q != {CNT_WIDTH{1'b1}})) begin
         carry_cnt_d = carry_cnt_q + CNT_WIDTH'(1);
      end
   end

   // Counter register, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_cnt_q <= '0;
      end else begin
         carry_cnt_q <= carry_cnt_d;
      end
   end

   assign carry_cnt = carry_cnt_q;
`else
   // No counter built: clr has no function in this build
   logic unused_clr;
   assign unused_clr = clr;
   assign carry_cnt  = '0;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: truth table, registered path, counter with
// clear priority, saturation on a 2-bit counter instance, and async reset.
module tb_half_adder;

`ifdef HALF_ADDER_CARRY_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        a, b, en, clr;
   logic        s, carry, s_q, carry_q, vld_q;
   logic [15:0] carry_cnt;
   logic        s2, carry2, s_q2, carry_q2, vld_q2;
   logic [1:0]  carry_cnt2;

   int n_chk;
   int n_err;

   half_adder #(.CNT_WIDTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en), .clr(clr),
      .s(s), .carry(carry), .s_q(s_q), .carry_q(carry_q), .vld_q(vld_q),
      .carry_cnt(carry_cnt)
   );

   half_adder #(.CNT_WIDTH(2)) u_dut_sat (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en), .clr(clr),
      .s(s2), .carry(carry2), .s_q(s_q2), .carry_q(carry_q2), .vld_q(vld_q2),
      .carry_cnt(carry_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] cexp(input int v);
      return CNT_ON ? 32'(v) : 32'd0;
   endfunction

   // expected (carry,s) for ab = 00,01,10,11
   logic [1:0] tt_exp [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
   logic [1:0] ab;
   int sat_exp [6] = '{1, 2, 3, 3, 3, 3};

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0; a = 1'b0; b = 1'b0; en = 1'b0; clr = 1'b0;
      #22;
      chk("rst_s_q", 32'(s_q), 32'd0);
      chk("rst_carry_q", 32'(carry_q), 32'd0);
      chk("rst_vld_q", 32'(vld_q), 32'd0);
      chk("rst_cnt", 32'(carry_cnt), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // truth table with en low
      for (int i = 0; i < 4; i++) begin
         ab = 2'(i);
         a = ab[1]; b = ab[0];
         #2;
         chk($sformatf("tt_s_%0d", i), 32'(s), 32'(tt_exp[i][0]));
         chk($sformatf("tt_c_%0d", i), 32'(carry), 32'(tt_exp[i][1]));
         #8;
      end

      // registered path
      @(negedge clk) begin en = 1'b1; a = 1'b1; b = 1'b1; end
      @(posedge clk) #1;
      chk("reg1_carry_q", 32'(carry_q), 32'd1);
      chk("reg1_s_q", 32'(s_q), 32'd0);
      chk("reg1_vld_q", 32'(vld_q), 32'd1);
      @(negedge clk) begin a = 1'b0; b = 1'b1; end
      @(posedge clk) #1;
      chk("reg2_carry_q", 32'(carry_q), 32'd0);
      chk("reg2_s_q", 32'(s_q), 32'd1);
      chk("reg2_vld_q", 32'(vld_q), 32'd1);
      @(negedge clk) begin en = 1'b0; a = 1'b1; b = 1'b1; end
      @(posedge clk) #1;
      chk("hold_vld_q", 32'(vld_q), 32'd0);
      chk("hold_s_q", 32'(s_q), 32'd1);
      chk("hold_carry_q", 32'(carry_q), 32'd0);

      // counter: clear, then 5 carry cycles
      @(negedge clk) clr = 1'b1;
      @(posedge clk) #1;
      chk("cnt_clr0", 32'(carry_cnt), 32'd0);
      @(negedge clk) begin clr = 1'b0; en = 1'b1; a = 1'b1; b = 1'b1; end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk) #1;
         chk($sformatf("sat_%0d", i), 32'(carry_cnt2), cexp(sat_exp[i]));
      end
      chk("cnt_5", 32'(carry_cnt), cexp(5));
      chk("cnt_regpath_carry_q", 32'(carry_q), 32'd1);
      @(posedge clk) #1;
      chk("sat_5", 32'(carry_cnt2), cexp(sat_exp[5]));
      chk("cnt_6", 32'(carry_cnt), cexp(6));
      // clear together with a carry: clear wins
      @(negedge clk) clr = 1'b1;
      @(posedge clk) #1;
      chk("cnt_clr_wins", 32'(carry_cnt), 32'd0);
      chk("sat_clr_wins", 32'(carry_cnt2), 32'd0);

      // build up some state, then reset mid-cycle
      @(negedge clk) begin clr = 1'b0; a = 1'b1; b = 1'b1; end
      @(negedge clk) begin a = 1'b0; b = 1'b1; end
      @(posedge clk) #1;
      chk("pre_rst_s_q", 32'(s_q), 32'd1);
      chk("pre_rst_cnt", 32'(carry_cnt), cexp(1));
      #1;
      rst_n = 1'b0; en = 1'b0; a = 1'b1; b = 1'b0;
      #1;
      chk("arst_s_q", 32'(s_q), 32'd0);
      chk("arst_carry_q", 32'(carry_q), 32'd0);
      chk("arst_vld_q", 32'(vld_q), 32'd0);
      chk("arst_cnt", 32'(carry_cnt), 32'd0);
      chk("arst_s", 32'(s), 32'd1);
      chk("arst_carry", 32'(carry), 32'd0);
      @(negedge clk) begin en = 1'b1; a = 1'b1; b = 1'b1; end
      @(posedge clk) #1;
      chk("in_rst_vld_q", 32'(vld_q), 32'd0);
      chk("in_rst_cnt", 32'(carry_cnt), 32'd0);
      chk("in_rst_carry", 32'(carry), 32'd1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk) #1;
      chk("post_rst_carry_q", 32'(carry_q), 32'd1);
      chk("post_rst_vld_q", 32'(vld_q), 32'd1);
      chk("post_rst_cnt", 32'(carry_cnt), cexp(1));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
